// File: rtl/keypad_bcd_encoder_pkg.sv
// keypad_bcd_encoder_pkg: shared constants for the keypad encoder.
// FSM state codes, BCD width, key count and the code bundle type.
package keypad_bcd_encoder_pkg;

  localparam int BCD_W = 4;
  localparam int KEY_N = 10;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  typedef struct packed {
    logic             multi;
    logic [BCD_W-1:0] bcd;
  } code_t;

endpackage

// File: rtl/keypad_bcd_encoder_if.sv
// keypad_bcd_encoder_if: digit output handshake bundle.
// bcd/multi/valid flow master->slave, ready flows slave->master.
interface keypad_bcd_encoder_if;
  import keypad_bcd_encoder_pkg::*;

  logic [BCD_W-1:0] bcd;
  logic             multi;
  logic             valid;
  logic             ready;

  modport master (
    output bcd,
    output multi,
    output valid,
    input  ready
  );

  modport slave (
    input  bcd,
    input  multi,
    input  valid,
    output ready
  );

endinterface

// File: rtl/keypad_bcd_encoder_dec_to_bcd_priority.sv
// dec_to_bcd_priority: 10-line pattern -> 4-bit code, highest index wins.
// Ports: pattern (in), code (out), multi (out, more than one bit set).
module dec_to_bcd_priority
  import keypad_bcd_encoder_pkg::*;
(
  input  logic [KEY_N-1:0] pattern,
  output logic [BCD_W-1:0] code,
  output logic             multi
);

  localparam logic [KEY_N-1:0] ONE = {{(KEY_N-1){1'b0}}, 1'b1};

  always_comb begin
    code = '0;
    for (int i = 0; i < KEY_N; i++) begin
      if (pattern[i]) begin
        code = BCD_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(pattern & (pattern - ONE));

endmodule

// File: rtl/keypad_bcd_encoder.sv
// keypad_bcd_encoder: sync + debounce + priority-encode a decimal keypad.
// Ports: clk, reset_b, key[9:0], clr_overrun, overrun, busy, digit (master).
module keypad_bcd_encoder
  import keypad_bcd_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [KEY_N-1:0] key,
  input  logic             clr_overrun,
  output logic             overrun,
  output logic             busy,
  keypad_bcd_encoder_if.master digit
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [KEY_N-1:0] key_m;
  logic [KEY_N-1:0] key_s;
  logic [KEY_N-1:0] pat;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] enc_bcd;
  logic             enc_multi;

  logic [BCD_W-1:0] bcd_q;
  logic             multi_q;
  logic             valid_q;

  logic key_any;
  logic same;
  logic cnt_done;
  logic accept;
  logic consume;
  logic drop;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      key_m <= '0;
      key_s <= '0;
    end else begin
      key_m <= key;
      key_s <= key_m;
    end
  end

  dec_to_bcd_priority u_enc (
    .pattern (pat),
    .code    (enc_bcd),
    .multi   (enc_multi)
  );

  assign key_any  = |key_s;
  assign same     = (key_s == pat);
  assign cnt_done = (cnt == CNT_LAST);

  // A press is accepted on the last matching debounce sample.
  assign accept = (state == ST_PRESS_DB) && key_any && same
                  && cnt_done;
  assign consume = valid_q && digit.ready;
  // Consumer freeing the slot this cycle still lets the new code in.
  assign drop = accept && valid_q && !digit.ready;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pat   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (key_any) begin
            pat   <= key_s;
            cnt   <= '0;
            state <= ST_PRESS_DB;
          end
        end
        ST_PRESS_DB: begin
          if (!key_any) begin
            state <= ST_IDLE;
          end else if (!same) begin
            pat <= key_s;
            cnt <= '0;
          end else if (cnt_done) begin
            state <= ST_HELD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HELD: begin
          // Pattern changes while held never yield a new digit.
          if (!key_any) begin
            cnt   <= '0;
            state <= ST_RELEASE_DB;
          end
        end
        ST_RELEASE_DB: begin
          if (key_any) begin
            state <= ST_HELD;
          end else if (cnt_done) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      bcd_q   <= '0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (accept && !drop) begin
      bcd_q   <= enc_bcd;
      multi_q <= enc_multi;
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign busy        = (state != ST_IDLE);
  assign digit.bcd   = bcd_q;
  assign digit.multi = multi_q;
  assign digit.valid = valid_q;

endmodule
